dram_port_arb: RTL

DRAM_PORT_ARB -- requirements
Module: dram_port_arb

---
 rtl/dram_port_arb_if.sv | 52 +++++
 rtl/dram_port_arb.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dram_port_arb_if.sv
// rtl/dram_port_arb_if.sv - requester, RAM-side and status signals of the two-port DRAM arbiter
interface dram_port_arb_if #(
    parameter int DWIDTH = 15
) ();
    logic                req0_ren;
    logic                req0_wen;
    logic [DWIDTH+1:2]   req0_adr;
    logic [31:0]         req0_wdata;
    logic                req0_gnt;
    logic                req0_rvalid;
    logic [31:0]         req0_rdata;

    logic                req1_ren;
    logic                req1_wen;
    logic [DWIDTH+1:2]   req1_adr;
    logic [31:0]         req1_wdata;
    logic                req1_gnt;
    logic                req1_rvalid;
    logic [31:0]         req1_rdata;

    logic [DWIDTH+1:2]   ram_adr;
    logic [31:0]         ram_wdata;
    logic                ram_wen;
    logic                ram_ren;
    logic [31:0]         ram_rdata;

    logic                owner;
    logic                busy;
    logic [15:0]         stall_cnt;

    // Arbiter side
    modport slave (
        input  req0_ren, req0_wen, req0_adr, req0_wdata,
        output req0_gnt, req0_rvalid, req0_rdata,
        input  req1_ren, req1_wen, req1_adr, req1_wdata,
        output req1_gnt, req1_rvalid, req1_rdata,
        output ram_adr, ram_wdata, ram_wen, ram_ren,
        input  ram_rdata,
        output owner, busy, stall_cnt
    );

    // Requesters and RAM side
    modport master (
        output req0_ren, req0_wen, req0_adr, req0_wdata,
        input  req0_gnt, req0_rvalid, req0_rdata,
        output req1_ren, req1_wen, req1_adr, req1_wdata,
        input  req1_gnt, req1_rvalid, req1_rdata,
        input  ram_adr, ram_wdata, ram_wen, ram_ren,
        output ram_rdata,
        input  owner, busy, stall_cnt
    );
endinterface

// File: rtl/dram_port_arb.sv
// rtl/dram_port_arb.sv - two-requester data RAM arbiter with burst-limited round robin
module dram_port_arb #(
    parameter int DWIDTH    = 15,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    dram_port_arb_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [2:0] MAX_B = 3'(MAX_BURST);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        last_owner_q, last_owner_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_own_q, rd_own_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        act0, act1;
    logic        gnt0, gnt1;
    logic        stall_inc;
    logic [DWIDTH+1:2] adr_mux;

    // Grant decision: a lone requester always wins; contention follows burst-limited round robin
    always_comb begin
        act0 = bus.req0_ren | bus.req0_wen;
        act1 = bus.req1_ren | bus.req1_wen;
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (act0 && !act1) begin
                gnt0 = 1'b1;
            end else if (act1 && !act0) begin
                gnt1 = 1'b1;
            end else if (act0 && act1) begin
                case (state_q)
                    OWN0: begin
                        if (cnt_q < MAX_B) gnt0 = 1'b1;
                        else               gnt1 = 1'b1;
                    end
                    OWN1: begin
                        if (cnt_q < MAX_B) gnt1 = 1'b1;
                        else               gnt0 = 1'b1;
                    end
                    default: begin
                        if (last_owner_q) gnt0 = 1'b1;
                        else              gnt1 = 1'b1;
                    end
                endcase
            end
        end
    end

    // Next-state, burst counter, read tracking and stall accounting
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        if (gnt0 || gnt1) begin
            state_d      = gnt1 ? OWN1 : OWN0;
            last_owner_d = gnt1;
            if (state_q == (gnt1 ? OWN1 : OWN0)) begin
                cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
            end else begin
                cnt_d = 3'd1;
            end
        end else begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end

        // A write wins over a simultaneous read, so such a request never produces rvalid
        rd_pend_d = (gnt0 & bus.req0_ren & ~bus.req0_wen) |
                    (gnt1 & bus.req1_ren & ~bus.req1_wen);
        rd_own_d  = rd_pend_d ? gnt1 : rd_own_q;

        stall_inc   = (act0 & ~gnt0) | (act1 & ~gnt1);
        stall_cnt_d = (stall_inc && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_owner_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_own_q     <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_own_q     <= rd_own_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // RAM-side mux: requester 0 drives address/data whenever requester 1 is not granted
    always_comb begin
        adr_mux       = gnt1 ? bus.req1_adr : bus.req0_adr;
        bus.ram_adr   = adr_mux;
        bus.ram_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
        bus.ram_wen   = (gnt0 & bus.req0_wen) | (gnt1 & bus.req1_wen);
        bus.ram_ren   = (gnt0 & bus.req0_ren & ~bus.req0_wen) |
                        (gnt1 & bus.req1_ren & ~bus.req1_wen);
    end

    // Requester-side returns and status
    always_comb begin
        bus.req0_gnt    = gnt0;
        bus.req1_gnt    = gnt1;
        bus.req0_rvalid = rd_pend_q & ~rd_own_q & ~rst;
        bus.req1_rvalid = rd_pend_q &  rd_own_q & ~rst;
        bus.req0_rdata  = bus.ram_rdata;
        bus.req1_rdata  = bus.ram_rdata;
        bus.owner       = last_owner_q;
        bus.busy        = (state_q != IDLE);
        bus.stall_cnt   = stall_cnt_q;
    end
endmodule
